memorio_bridge: RTL
===================

MEMORIO_BRIDGE -- requirements
Module: memorio_bridge

Interface
REQ-001 Parameter NUM_IO, 4, number of I/O channels (1..16), each a 16-byte slot from IO_BASE.
REQ-002 Parameter IO_BASE, 32'hFFFFFC60, byte address of channel 0; channel k at IO_BASE+16*k.
REQ-003 Parameter IO_W, 16, per-channel read-data width (1..32), zero-extended to 32.
REQ-004 Parameter WAIT_CYCLES, 1, minimum cycles io_cs is held before io_ready is sampled (0..255).
REQ-005 Parameter TIMEOUT, 64, cycles in IO_WAIT before abort (must exceed WAIT_CYCLES).
REQ-006 clock  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 caddress  in  32  access address from ALU result.
REQ-009 memread, memwrite, ioread, iowrite  in  1 each  access-type strobes from control unit.
REQ-010 wdata  in  32  store data from register file.
REQ-011 mread_data  in  32  data-memory read data.
REQ-012 ioread_data  in  NUM_IO*IO_W  packed channel read data, channel k at bits [k*IO_W +: IO_W].
REQ-013 io_ready  in  1  peripheral acknowledge.
REQ-014 size  in  2  store size: 0 byte, 1 half, 2 word.
REQ-015 address  out  32  caddress passed through combinationally.
REQ-016 write_data  out  32  wdata while memwrite or iowrite, else 32'h0.
REQ-017 rdata  out  32  read data to register file.
REQ-018 io_cs  out  NUM_IO  registered one-hot channel select.
REQ-019 io_rd, io_wr  out  1 each  registered direction strobes, valid with io_cs.
REQ-020 stall  out  1  freeze pipeline while I/O access incomplete.
REQ-021 bus_err  out  1  sticky error flag.
REQ-022 byte_en  out  4  write byte lanes.

Function
REQ-023 FSM states IDLE, IO_WAIT, DONE; reset state IDLE.
REQ-024 Memory access (memread/memwrite, no io strobe): no state change, stall=0, rdata=mread_data combinationally.
REQ-025 I/O request in IDLE: decode k=(caddress-IO_BASE)>>4; hit if caddress>=IO_BASE and k<NUM_IO.
REQ-026 Hit: stall=1 combinationally in the request cycle; next edge io_cs[k]=1, io_rd/io_wr latched, wait counter=0, enter IO_WAIT.
REQ-027 IO_WAIT: stall=1; counter increments each cycle (saturating at 255); complete in first cycle with counter>=WAIT_CYCLES and io_ready=1.
REQ-028 Completion: latch zero-extended ioread_data channel k (0 for writes), clear io_cs/io_rd/io_wr, enter DONE.
REQ-029 DONE: stall=0, rdata=latched value, return to IDLE next edge; a new request in DONE is ignored (the CPU re-presents it in IDLE).
REQ-030 Timeout: counter reaching TIMEOUT in IO_WAIT sets bus_err, latches 0, enters DONE.
REQ-031 Miss (unmapped I/O address): bus_err set next edge, stall=0, rdata=0, no io_cs.
REQ-032 Simultaneous memory and I/O strobes: treated as error; bus_err set, no access, stall=0, rdata=0.
REQ-033 In IDLE with no request rdata=0; io_ready outside IO_WAIT is ignored.
REQ-034 bus_err clears only on reset.

Reset
REQ-035 reset low asynchronously forces IDLE, io_cs=0, io_rd=0, io_wr=0, counter=0, latched data=0, bus_err=0; stall=0, rdata=0 follow combinationally.
REQ-036 Reset mid-access aborts the transaction without completion; the first request after reset release is decoded normally.

Configuration
REQ-037 Macro MEMORIO_BYTE_LANE_EN defined: byte_en=4'b0001<<caddress[1:0] for size 0, 4'b0011<<(caddress[1]*2) for size 1, 4'hF for size 2; write_data replicates the low byte/half to all lanes.
REQ-038 Macro undefined: byte_en=4'hF on any write, 0 otherwise; write_data=wdata unmodified; size ignored.

Verification
REQ-039 ioread 32'hFFFFFC70, NUM_IO=4, WAIT_CYCLES=2, io_ready held 1, ch1 data 16'hA5A5 -> io_cs=4'b0010 cycles 1-3, stall 1 cycles 0-3, rdata=32'h0000A5A5 cycle 4.
REQ-040 memread 32'h00000010, mread_data 32'h12345678 -> rdata same cycle, stall 0, io_cs 0.
REQ-041 ioread 32'hFFFFFCA0 (k=4, miss) -> bus_err 1 next edge, rdata 0, no stall; persists until reset.
REQ-042 iowrite ch0, io_ready held 0, TIMEOUT=64 -> io_cs[0]/io_wr high 64 cycles, then bus_err 1, stall drops in DONE.
REQ-043 reset low during IO_WAIT -> io_cs, stall, bus_err 0 immediately; next ioread completes normally.
REQ-044 With MEMORIO_BYTE_LANE_EN, memwrite size 0, caddress[1:0]=2, wdata 32'h000000EE -> byte_en 4'b0100, write_data 32'hEEEEEEEE.

Source files
------------

// File: rtl/memorio_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// memorio_bridge : routes CPU loads/stores to data memory or memory-mapped I/O
// channels; macro MEMORIO_BYTE_LANE_EN enables sized byte lanes.   Rev 1.0
// ---------------------------------------------------------------------------
module memorio_bridge #(
  parameter int          NUM_IO      = 4,
  parameter logic [31:0] IO_BASE     = 32'hFFFFFC60,
  parameter int          IO_W        = 16,
  parameter int          WAIT_CYCLES = 1,
  parameter int          TIMEOUT     = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [31:0]              caddress,
  input  logic                     memread,
  input  logic                     memwrite,
  input  logic                     ioread,
  input  logic                     iowrite,
  input  logic [31:0]              wdata,
  input  logic [31:0]              mread_data,
  input  logic [NUM_IO*IO_W-1:0]   ioread_data,
  input  logic                     io_ready,
  input  logic [1:0]               size,
  output logic [31:0]              address,
  output logic [31:0]              write_data,
  output logic [31:0]              rdata,
  output logic [NUM_IO-1:0]        io_cs,
  output logic                     io_rd,
  output logic                     io_wr,
  output logic                     stall,
  output logic                     bus_err,
  output logic [3:0]               byte_en
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_IO_WAIT = 2'd1;
  localparam logic [1:0] c_DONE    = 2'd2;

  localparam logic [7:0] c_WAIT     = 8'(WAIT_CYCLES);
  // Abort on the edge where the counter would reach TIMEOUT.
  localparam logic [8:0] c_TMO_LAST = 9'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [NUM_IO-1:0] r_cs;
  logic              r_rd;
  logic              r_wr;
  logic              r_err;
  logic [7:0]        r_cnt;
  logic [31:0]       r_data;

  logic              w_io_req;
  logic              w_mem_req;
  logic              w_conflict;
  logic              w_hit;
  logic              w_wr;
  logic              w_done_ok;
  logic              w_timeout;
  logic [31:0]       w_off;
  logic [31:0]       w_ch_data;
  logic [NUM_IO-1:0] w_sel;

  assign w_io_req   = ioread | iowrite;
  assign w_mem_req  = memread | memwrite;
  assign w_conflict = w_io_req & w_mem_req;
  assign w_wr       = memwrite | iowrite;
  assign w_off      = caddress - IO_BASE;

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      w_sel[k] = (w_off[31:4] == 28'(k));
    end
  end

  assign w_hit = (caddress >= IO_BASE) && (|w_sel);

  always_comb begin
    w_ch_data = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      if (r_cs[k]) begin
        w_ch_data[IO_W-1:0] = ioread_data[k*IO_W +: IO_W];
      end
    end
  end

  assign w_done_ok = (r_cnt >= c_WAIT) && io_ready;
  assign w_timeout = ({1'b0, r_cnt} >= c_TMO_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
      r_cs    <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= 8'd0;
      r_data  <= 32'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_conflict) begin
            r_err <= 1'b1;
          end else if (w_io_req) begin
            if (w_hit) begin
              r_cs    <= w_sel;
              r_rd    <= ioread;
              r_wr    <= iowrite;
              r_cnt   <= 8'd0;
              r_state <= c_IO_WAIT;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        c_IO_WAIT: begin
          if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
          end
          // A completion in the same cycle as the timeout still wins.
          if (w_done_ok || w_timeout) begin
            r_data  <= (w_done_ok && !r_wr) ? w_ch_data : 32'd0;
            r_cs    <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_state <= c_DONE;
            if (!w_done_ok) begin
              r_err <= 1'b1;
            end
          end
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign address = caddress;
  assign io_cs   = r_cs;
  assign io_rd   = r_rd;
  assign io_wr   = r_wr;
  assign bus_err = r_err;
  assign stall   = (r_state == c_IO_WAIT) ||
                   ((r_state == c_IDLE) && w_io_req && !w_mem_req && w_hit);

  always_comb begin
    rdata = 32'd0;
    if (r_state == c_DONE) begin
      rdata = r_data;
    end else if ((r_state == c_IDLE) && w_mem_req && !w_io_req) begin
      rdata = mread_data;
    end
  end

`ifdef MEMORIO_BYTE_LANE_EN
  logic [3:0] w_unused_bits;
  assign w_unused_bits = w_off[3:0];

  always_comb begin
    byte_en    = 4'h0;
    write_data = 32'd0;
    if (w_wr) begin
      case (size)
        2'd0: begin
          byte_en    = 4'b0001 << caddress[1:0];
          write_data = {4{wdata[7:0]}};
        end
        2'd1: begin
          byte_en    = 4'b0011 << {caddress[1], 1'b0};
          write_data = {2{wdata[15:0]}};
        end
        default: begin
          byte_en    = 4'hF;
          write_data = wdata;
        end
      endcase
    end
  end
`else
  logic [5:0] w_unused_bits;
  assign w_unused_bits = {w_off[3:0], size};

  assign byte_en    = w_wr ? 4'hF : 4'h0;
  assign write_data = w_wr ? wdata : 32'd0;
`endif

endmodule
`default_nettype wire
